// File: rtl/round_controller_pipelined_pkg.sv
// Shared definitions for the masked-cipher round sequencer: FSM encoding, width helper
// and Midori round/stage defaults.
package round_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } ctrl_state_e;

  localparam int MIDORI64_SBOX_STAGES  = 3;
  localparam int MIDORI64_NUM_ROUNDS   = 16;
  localparam int MIDORI128_SBOX_STAGES = 3;
  localparam int MIDORI128_NUM_ROUNDS  = 20;

  // Bits needed to index v distinct values (0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/round_controller_pipelined_if.sv
// Handshake and sequencing bus between the round controller and its user.
// rnd_valid is only present when RND_STALL_EN is defined.
interface round_controller_pipelined_if #(
  parameter int ROUND_W = 4,
  parameter int STAGE_W = 2
);
  logic               start;
  logic               dec;
`ifdef RND_STALL_EN
  logic               rnd_valid;
`endif
  logic [ROUND_W-1:0] round;
  logic [STAGE_W-1:0] stage;
  logic               round_start_sel;
  logic               en;
  logic               last_round;
  logic               busy;
  logic               done;

  modport master (
    output start,
    output dec,
`ifdef RND_STALL_EN
    output rnd_valid,
`endif
    input  round,
    input  stage,
    input  round_start_sel,
    input  en,
    input  last_round,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  dec,
`ifdef RND_STALL_EN
    input  rnd_valid,
`endif
    output round,
    output stage,
    output round_start_sel,
    output en,
    output last_round,
    output busy,
    output done
  );
endinterface

// File: rtl/round_controller_pipelined_counter.sv
// Loadable up/down counter over 0..MAX with terminal-count flag; wraps at the terminal
// value when enabled there (callers that must not wrap gate en with tc).
module ctrl_updown_counter #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         up,
  output logic [W-1:0] cnt,
  output logic         tc
);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign tc = up ? (cnt == MAX_V) : (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      if (up) cnt <= tc ? '0 : cnt + 1'b1;
      else    cnt <= tc ? MAX_V : cnt - 1'b1;
    end
  end
endmodule

// File: rtl/round_controller_pipelined.sv
// Round/stage sequencer for a masked block-cipher datapath with a pipelined S-box layer.
// Optional macro RND_STALL_EN: freeze the RUN phase while rnd_valid is low.
module round_controller_pipelined
  import round_ctrl_pkg::*;
#(
  parameter int SBOX_STAGES = MIDORI64_SBOX_STAGES,
  parameter int NUM_ROUNDS  = MIDORI64_NUM_ROUNDS,
  parameter int ROUND_W     = 4,
  parameter int STAGE_W     = 2
) (
  input logic                        clk,
  input logic                        reset,
  round_controller_pipelined_if.slave bus
);

  if (SBOX_STAGES < 1 || NUM_ROUNDS < 2 || STAGE_W < 1 ||
      ROUND_W < clog2(NUM_ROUNDS) || STAGE_W < clog2(SBOX_STAGES)) begin : g_bad_params
    $fatal(1, "round_controller_pipelined: illegal SBOX_STAGES/NUM_ROUNDS/width combination");
  end

  localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(NUM_ROUNDS - 1);

  ctrl_state_e        state;
  logic               dir;
  logic               rsel_q;
  logic               busy_q;
  logic               done_q;
  logic               rnd_ok;
  logic               start_acc;
  logic               run_step;
  logic               stage_tc;
  logic               round_tc;
  logic [STAGE_W-1:0] stage_cnt;
  logic [ROUND_W-1:0] round_cnt;

`ifdef RND_STALL_EN
  assign rnd_ok = bus.rnd_valid;
`else
  assign rnd_ok = 1'b1;
`endif

  // start is only honoured when no run is in flight
  assign start_acc = bus.start && (state == ST_IDLE || state == ST_DONE);
  assign run_step  = (state == ST_RUN) && rnd_ok;

  ctrl_updown_counter #(.W(STAGE_W), .MAX(SBOX_STAGES - 1)) u_stage_cnt (
    .clk      (clk),
    .reset    (reset),
    .en       (run_step),
    .load     (start_acc),
    .load_val ('0),
    .up       (1'b1),
    .cnt      (stage_cnt),
    .tc       (stage_tc)
  );

  // Round terminal count doubles as last_round: it tracks the latched direction.
  ctrl_updown_counter #(.W(ROUND_W), .MAX(NUM_ROUNDS - 1)) u_round_cnt (
    .clk      (clk),
    .reset    (reset),
    .en       (run_step && stage_tc && !round_tc),
    .load     (start_acc),
    .load_val (bus.dec ? ROUND_LAST : '0),
    .up       (!dir),
    .cnt      (round_cnt),
    .tc       (round_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      dir    <= 1'b0;
      rsel_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state  <= ST_LOAD;
            dir    <= bus.dec;
            rsel_q <= 1'b1;
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          state  <= ST_RUN;
          rsel_q <= 1'b0;
        end
        ST_RUN: begin
          if (run_step && stage_tc && round_tc) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          rsel_q <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.round           = round_cnt;
  assign bus.stage           = stage_cnt;
  assign bus.round_start_sel = rsel_q;
  assign bus.en              = rsel_q || run_step;
  assign bus.last_round      = round_tc;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;

endmodule

// File: tb/tb_round_controller_pipelined.sv
// Bench for round_controller_pipelined: default Midori64 instance plus a minimal
// SBOX_STAGES=1/NUM_ROUNDS=2 instance; stall scenarios active when RND_STALL_EN is defined.
module tb_round_controller_pipelined;
  localparam int R = 16;
  localparam int S = 3;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  round_controller_pipelined_if #(.ROUND_W(4), .STAGE_W(2)) bus ();
  round_controller_pipelined_if #(.ROUND_W(1), .STAGE_W(1)) bus2 ();

  round_controller_pipelined #(.SBOX_STAGES(S), .NUM_ROUNDS(R), .ROUND_W(4), .STAGE_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  round_controller_pipelined #(.SBOX_STAGES(1), .NUM_ROUNDS(2), .ROUND_W(1), .STAGE_W(1)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  // {round, stage, round_start_sel, en, last_round, busy, done}
  logic [10:0] obs;
  logic [6:0]  obs2;
  assign obs  = {bus.round, bus.stage, bus.round_start_sel, bus.en, bus.last_round, bus.busy, bus.done};
  assign obs2 = {bus2.round, bus2.stage, bus2.round_start_sel, bus2.en, bus2.last_round, bus2.busy, bus2.done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    logic [10:0] e;
    logic [6:0]  e2;
    reset = 1'b1;
    bus.start = 1'b0; bus.dec = 1'b0; bus2.start = 1'b0; bus2.dec = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    e = '0; e2 = '0;
    total_cnt++;
    if (obs !== e) $display("FAIL reset_state: got %h want %h", obs, e); else pass_cnt++;
    total_cnt++;
    if (obs2 !== e2) $display("FAIL reset_state_small: got %h want %h", obs2, e2); else pass_cnt++;
    // reset must win over start
    bus.start = 1'b1; bus.dec = 1'b1;
    @(negedge clk);
    #1;
    total_cnt++;
    if (obs !== e) $display("FAIL reset_beats_start: got %h want %h", obs, e); else pass_cnt++;
    bus.start = 1'b0; bus.dec = 1'b0;
    reset = 1'b0;
  endtask

  // One full run checked cycle by cycle against the round/stage schedule.
  task automatic test_run(input string name, input bit d, input bit hold_start, input bit rand_stall);
    logic [10:0] e;
    int k, edges, stalls, er, es;
    bit rv;
    @(negedge clk);
    bus.start = 1'b1; bus.dec = d;
`ifdef RND_STALL_EN
    bus.rnd_valid = 1'b1;
`endif
    @(negedge clk);
    bus.start = hold_start; bus.dec = ~d;
    #1;
    edges = 1;
    er = d ? R - 1 : 0;
    e = {4'(er), 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    total_cnt++;
    if (obs !== e) $display("FAIL %s load: got %h want %h", name, obs, e); else pass_cnt++;
    k = 0; stalls = 0;
    while (k < R * S && edges < 400) begin
      @(negedge clk);
      edges++;
      rv = rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
`ifdef RND_STALL_EN
      bus.rnd_valid = rv;
`else
      rv = 1'b1;
`endif
      #1;
      er = d ? R - 1 - k / S : k / S;
      es = k % S;
      e = {4'(er), 2'(es), 1'b0, rv, (k / S == R - 1), 1'b1, 1'b0};
      total_cnt++;
      if (obs !== e) $display("FAIL %s run k=%0d: got %h want %h", name, k, obs, e); else pass_cnt++;
      if (rv) k++; else stalls++;
    end
    @(negedge clk);
    edges++;
    bus.start = 1'b0;
`ifdef RND_STALL_EN
    bus.rnd_valid = 1'b1;
`endif
    #1;
    er = d ? 0 : R - 1;
    e = {4'(er), 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    total_cnt++;
    if (obs !== e) $display("FAIL %s done: got %h want %h", name, obs, e); else pass_cnt++;
    total_cnt++;
    if (edges - 1 !== 1 + R * S + stalls)
      $display("FAIL %s latency: got %0d want %0d", name, edges - 1, 1 + R * S + stalls);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (obs !== e) $display("FAIL %s done_hold: got %h want %h", name, obs, e); else pass_cnt++;
  endtask

  task automatic test_reset_midrun();
    logic [10:0] e;
    bit seen_done;
    @(negedge clk);
    bus.start = 1'b1; bus.dec = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (23) @(negedge clk);
    #1;
    e = {4'd7, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    total_cnt++;
    if (obs !== e) $display("FAIL midrun_position: got %h want %h", obs, e); else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    e = '0;
    total_cnt++;
    if (obs !== e) $display("FAIL midrun_reset: got %h want %h", obs, e); else pass_cnt++;
    seen_done = 1'b0;
    repeat (60) begin
      @(negedge clk);
      #1;
      if (bus.done || bus.en) seen_done = 1'b1;
    end
    total_cnt++;
    if (seen_done !== 1'b0) $display("FAIL midrun_abandoned: got %0d want 0", seen_done); else pass_cnt++;
  endtask

  task automatic test_small(input bit d);
    logic [6:0] exp_seq [4];
    exp_seq[0] = {d,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_seq[1] = {d,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_seq[2] = {~d, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_seq[3] = {~d, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    @(negedge clk);
    bus2.start = 1'b1; bus2.dec = d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus2.start = 1'b0;
      #1;
      total_cnt++;
      if (obs2 !== exp_seq[i]) $display("FAIL small dec=%0d step%0d: got %h want %h", d, i, obs2, exp_seq[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random_runs();
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      test_run("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end
  endtask

`ifdef RND_STALL_EN
  task automatic test_stall();
    logic [10:0] e;
    int edges;
    @(negedge clk);
    bus.start = 1'b1; bus.dec = 1'b0; bus.rnd_valid = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    edges = 1;
    repeat (15) begin @(negedge clk); edges++; end
    bus.rnd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      e = {4'd4, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      total_cnt++;
      if (obs !== e) $display("FAIL stall_freeze %0d: got %h want %h", i, obs, e); else pass_cnt++;
      @(negedge clk);
      edges++;
    end
    bus.rnd_valid = 1'b1;
    while (!bus.done && edges < 200) begin @(negedge clk); edges++; end
    total_cnt++;
    if (edges - 1 !== 54) $display("FAIL stall_latency: got %0d want 54", edges - 1); else pass_cnt++;
  endtask
`endif

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.dec = 1'b0;
    bus2.start = 1'b0; bus2.dec = 1'b0;
`ifdef RND_STALL_EN
    bus.rnd_valid = 1'b1;
    bus2.rnd_valid = 1'b1;
`endif
    test_reset();
    test_run("encrypt", 1'b0, 1'b0, 1'b0);
    test_run("decrypt", 1'b1, 1'b0, 1'b0);
    test_run("start_held", 1'b0, 1'b1, 1'b0);
    test_run("back_to_back", 1'b1, 1'b1, 1'b0);
    test_reset_midrun();
    test_small(1'b0);
    test_small(1'b1);
    test_random_runs();
`ifdef RND_STALL_EN
    test_stall();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
